drrip_tag_ctrl: RTL and testbench
=================================

Name: drrip_tag_ctrl

Overview:
- Initiator-side controller for the drrip_cache replacement engine.
- Accepts CPU lookup requests and owns the tag/valid arrays for NUM_SETS x NUM_WAYS.
- Drives valid/set_index/access_way/hit/miss into drrip_cache. On a miss, waits for victim_ready, fills the tag into victim_way, then returns the response to the requester.

Parameters:
- NUM_WAYS, 4, ways per set; victim_way/access_way are fixed 4 bits.
- NUM_SETS, 8, number of sets.
- SET_INDEX_WIDTH, $clog2(NUM_SETS), set index width.
- TAG_WIDTH, 8, tag bits; req_addr = {tag, set}.
- TIMEOUT_CYCLES, 64, maximum cycles in MISS_WAIT before an error response.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  1  lookup request.
- req_ready  output  1  controller can accept a request.
- req_addr  input  TAG_WIDTH+SET_INDEX_WIDTH  {tag, set_index}.
- flush  input  1  invalidate all lines (1-cycle pulse).
- resp_valid  output  1  1-cycle response pulse.
- resp_hit  output  1  1 = hit, 0 = miss fill.
- resp_way  output  4  way hit or filled.
- resp_err  output  1  miss aborted (timeout or bad victim); no fill done.
- valid  output  1  to drrip_cache: access active.
- set_index  output  SET_INDEX_WIDTH  to drrip_cache.
- access_way  output  4  to drrip_cache: hit way (0 on miss).
- hit  output  1  to drrip_cache.
- miss  output  1  to drrip_cache.
- victim_way  input  4  from drrip_cache.
- victim_ready  input  1  from drrip_cache: victim_way valid.
- hit_count  output  16  saturating hit counter.
- miss_count  output  16  saturating miss counter (counts aborted misses too).

Behaviour:
- Reset (rst low, async): state=IDLE; all valid bits cleared; all outputs 0, including req_ready and both counters. req_ready rises on the first clk after rst deasserts.
- A mid-operation reset drops valid/hit/miss immediately and discards the request with no response.
- FSM states: IDLE, LOOKUP, HIT_NOTIFY, MISS_WAIT, RESP.
- IDLE:
  - req_ready=1 only here.
  - On req_valid&&req_ready, register tag and set; go to LOOKUP.
  - If flush is high in the same cycle, the flush wins: all valid bits clear, the request is not accepted, and req_ready=0 for that cycle.
- LOOKUP (1 cycle): compare the registered tag against the valid ways of the set.
  - Match: latch the lowest matching way; go to HIT_NOTIFY.
  - Else: go to MISS_WAIT.
- HIT_NOTIFY (exactly 1 cycle): valid=1, hit=1, miss=0, access_way=hit way. Increment hit_count; go to RESP.
- MISS_WAIT:
  - Outputs: valid=1, miss=1, hit=0, access_way=0, set_index held stable; wait counter runs.
  - victim_ready high at a posedge with victim_way<NUM_WAYS: write the tag and set the valid bit in [set][victim_way] at that edge; resp_way=victim_way; increment miss_count; go to RESP.
  - victim_ready with victim_way>=NUM_WAYS: no fill; resp_err=1; increment miss_count; go to RESP.
  - Wait counter reaching TIMEOUT_CYCLES: same as the bad-victim case (resp_err=1, no fill, miss_count++).
  - victim_ready in any other state is ignored.
- RESP (1 cycle): resp_valid=1 with resp_hit/resp_way/resp_err; valid/hit/miss=0; go to IDLE.
- flush outside IDLE is latched as pending and applied on entry to IDLE, before any new request is accepted.
- Latency from accept to resp_valid:
  - Hit: 3 cycles.
  - Miss: 3 + N cycles, where N = cycles in MISS_WAIT before victim_ready is sampled (N >= 0 if ready is already high on the first MISS_WAIT edge → 3).
- Counters saturate at 0xFFFF and never wrap.
- resp_* outputs are 0 whenever resp_valid=0.

Test Plan:
1. Reset; request addr 0x090 (tag 0x12, set 0); bench drives victim_ready on the 3rd MISS_WAIT cycle with victim_way=2 → valid=1 and miss=1 for exactly 3 cycles with set_index=0; then resp_valid, resp_hit=0, resp_way=2, resp_err=0; miss_count=1.
2. Repeat 0x090 → valid&hit for one cycle with access_way=2 and miss=0; resp_valid 3 cycles after accept with resp_hit=1, resp_way=2; hit_count=1.
3. Request 0x095 (tag 0x12, set 5) → miss with set_index=5; victim_way=0 → filled. Re-request 0x095 → hit way 0. Set 0 line is unaffected (0x090 still hits way 2).
4. TIMEOUT_CYCLES=16, victim_ready held low → miss held 16 cycles, then resp_err=1 and valid/miss drop. Re-request the same addr → misses again (no fill occurred).
5. victim_ready with victim_way=4 → resp_err=1, no fill, miss_count increments. Request with flush in the same IDLE cycle → not accepted; 0x090 subsequently misses.
6. Assert rst low mid-MISS_WAIT → valid/miss/req_ready drop to 0 asynchronously, counters read 0, no resp_valid. After release, 0x090 misses.
7. Force hit_count to 0xFFFF, then hit → hit_count stays 0xFFFF.

Source files
------------

// File: rtl/drrip_tag_ctrl.sv
// Tag/valid owner in front of the DRRIP replacement engine: looks up CPU
// requests, reports hit/miss to the engine and fills the victim way on a miss.
module drrip_tag_ctrl #(
    parameter int NUM_WAYS        = 4,
    parameter int NUM_SETS        = 8,
    parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
    parameter int TAG_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [TAG_WIDTH+SET_INDEX_WIDTH-1:0] req_addr,
    input  logic                                 flush,
    output logic                                 resp_valid,
    output logic                                 resp_hit,
    output logic [3:0]                           resp_way,
    output logic                                 resp_err,
    output logic                                 valid,
    output logic [SET_INDEX_WIDTH-1:0]           set_index,
    output logic [3:0]                           access_way,
    output logic                                 hit,
    output logic                                 miss,
    input  logic [3:0]                           victim_way,
    input  logic                                 victim_ready,
    output logic [15:0]                          hit_count,
    output logic [15:0]                          miss_count
);

    localparam int AW = TAG_WIDTH + SET_INDEX_WIDTH;
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        HIT_NOTIFY,
        MISS_WAIT,
        RESP
    } state_t;

    state_t                         state_q, state_d;
    logic [TAG_WIDTH-1:0]           tag_q [NUM_SETS][NUM_WAYS];
    logic [TAG_WIDTH-1:0]           tag_d [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]            vld_q [NUM_SETS];
    logic [NUM_WAYS-1:0]            vld_d [NUM_SETS];
    logic [TAG_WIDTH-1:0]           req_tag_q, req_tag_d;
    logic [SET_INDEX_WIDTH-1:0]     set_q, set_d;
    logic [3:0]                     way_q, way_d;
    logic [TW-1:0]                  timer_q, timer_d;
    logic                           flush_pend_q, flush_pend_d;
    logic                           ready_q, ready_d;
    logic                           valid_q, valid_d;
    logic                           hit_q, hit_d;
    logic                           miss_q, miss_d;
    logic [3:0]                     access_way_q, access_way_d;
    logic                           resp_valid_q, resp_valid_d;
    logic                           resp_hit_q, resp_hit_d;
    logic [3:0]                     resp_way_q, resp_way_d;
    logic                           resp_err_q, resp_err_d;
    logic [15:0]                    hit_cnt_q, hit_cnt_d;
    logic [15:0]                    miss_cnt_q, miss_cnt_d;

    logic                           match;
    logic [3:0]                     match_way;
    logic                           victim_ok;
    logic                           timed_out;

    // Descending scan so the lowest matching way wins.
    always_comb begin
        match     = 1'b0;
        match_way = 4'd0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (vld_q[set_q][w] && (tag_q[set_q][w] == req_tag_q)) begin
                match     = 1'b1;
                match_way = 4'(w);
            end
        end
    end

    assign victim_ok = (32'(victim_way) < NUM_WAYS);
    assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        vld_d        = vld_q;
        req_tag_d    = req_tag_q;
        set_d        = set_q;
        way_d        = way_q;
        timer_d      = timer_q;
        flush_pend_d = flush_pend_q | (flush && (state_q != IDLE));
        valid_d      = 1'b0;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        access_way_d = 4'd0;
        resp_valid_d = 1'b0;
        resp_hit_d   = 1'b0;
        resp_way_d   = 4'd0;
        resp_err_d   = 1'b0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    vld_d = '{default: '0};
                end else if (req_valid && ready_q) begin
                    req_tag_d = req_addr[AW-1:SET_INDEX_WIDTH];
                    set_d     = req_addr[SET_INDEX_WIDTH-1:0];
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                valid_d = 1'b1;
                timer_d = '0;
                if (match) begin
                    way_d        = match_way;
                    hit_d        = 1'b1;
                    access_way_d = match_way;
                    state_d      = HIT_NOTIFY;
                end else begin
                    miss_d  = 1'b1;
                    state_d = MISS_WAIT;
                end
            end
            HIT_NOTIFY: begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                resp_valid_d = 1'b1;
                resp_hit_d   = 1'b1;
                resp_way_d   = way_q;
                state_d      = RESP;
            end
            MISS_WAIT: begin
                if (victim_ready || timed_out) begin
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                    // A ready victim takes priority over an expiring timer.
                    if (victim_ready && victim_ok) begin
                        tag_d[set_q][victim_way[WW-1:0]] = req_tag_q;
                        vld_d[set_q][victim_way[WW-1:0]] = 1'b1;
                        resp_way_d = victim_way;
                    end else begin
                        resp_err_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                    valid_d = 1'b1;
                    miss_d  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (flush_pend_q || flush) begin
                    vld_d        = '{default: '0};
                    flush_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tag_q        <= '{default: '0};
            vld_q        <= '{default: '0};
            req_tag_q    <= '0;
            set_q        <= '0;
            way_q        <= '0;
            timer_q      <= '0;
            flush_pend_q <= 1'b0;
            ready_q      <= 1'b0;
            valid_q      <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            access_way_q <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_err_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            vld_q        <= vld_d;
            req_tag_q    <= req_tag_d;
            set_q        <= set_d;
            way_q        <= way_d;
            timer_q      <= timer_d;
            flush_pend_q <= flush_pend_d;
            ready_q      <= ready_d;
            valid_q      <= valid_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            access_way_q <= access_way_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
            resp_err_q   <= resp_err_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // A same-cycle flush blocks acceptance, so ready must see it directly.
    assign req_ready  = ready_q & ~flush;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_way   = resp_way_q;
    assign resp_err   = resp_err_q;
    assign valid      = valid_q;
    assign set_index  = set_q;
    assign access_way = access_way_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_drrip_tag_ctrl.sv
// Directed bench for drrip_tag_ctrl: expected responses go into a queue
// that a negedge monitor drains whenever resp_valid is seen.
module tb_drrip_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_hit;
    logic [3:0]  resp_way;
    logic        resp_err;
    logic        valid;
    logic [2:0]  set_index;
    logic [3:0]  access_way;
    logic        hit;
    logic        miss;
    logic [3:0]  victim_way;
    logic        victim_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [5:0] sb [$];

    drrip_tag_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_err(resp_err),
        .valid(valid), .set_index(set_index), .access_way(access_way),
        .hit(hit), .miss(miss),
        .victim_way(victim_way), .victim_ready(victim_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {26'd0, resp_hit, resp_way, resp_err}, 32'hDEAD);
            end else begin
                chk("resp", {26'd0, resp_hit, resp_way, resp_err}, {26'd0, sb.pop_front()});
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // vat: MISS_WAIT cycle (1-based) on which victim_ready is driven; 0 = never
    task automatic txn(input string name, input logic [10:0] addr,
                       input logic exp_hit, input logic [3:0] exp_way,
                       input logic exp_err, input int vat, input logic [3:0] vway,
                       input int exp_lat);
        int k = 0;
        int mc = 0;
        int hc = 0;
        int lat = -1;
        logic bad_set = 1'b0;
        logic [3:0] aw = 4'hF;
        wait_ready();
        req_valid = 1'b1;
        req_addr  = addr;
        sb.push_back({exp_hit, exp_way, exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (lat < 0 && k < 100) begin
            @(negedge clk);
            victim_ready = 1'b0;
            k++;
            if (valid && miss) begin
                mc++;
                if (set_index != addr[2:0]) bad_set = 1'b1;
                if (mc == vat) begin
                    victim_ready = 1'b1;
                    victim_way   = vway;
                end
            end
            if (valid && hit) begin
                hc++;
                aw = access_way;
            end
            if (resp_valid) lat = k;
        end
        victim_ready = 1'b0;
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_miss_cycles"}, mc, exp_hit ? 0 : exp_lat - 2);
        chk({name, "_hit_cycles"}, hc, exp_hit ? 1 : 0);
        chk({name, "_set_index"}, {31'd0, bad_set}, 32'd0);
        if (exp_hit) chk({name, "_access_way"}, {28'd0, aw}, {28'd0, exp_way});
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        flush        = 1'b0;
        victim_way   = '0;
        victim_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_counts", {hit_count, miss_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // 1: cold miss, victim on 3rd MISS_WAIT cycle
        txn("t1_miss", 11'h090, 1'b0, 4'd2, 1'b0, 3, 4'd2, 5);
        chk("t1_miss_count", miss_count, 1);

        // 2: same address hits way 2
        txn("t2_hit", 11'h090, 1'b1, 4'd2, 1'b0, 0, 4'd0, 3);
        chk("t2_hit_count", hit_count, 1);

        // 3: other set, fill way 0, set 0 untouched
        txn("t3_miss", 11'h095, 1'b0, 4'd0, 1'b0, 1, 4'd0, 3);
        txn("t3_hit5", 11'h095, 1'b1, 4'd0, 1'b0, 0, 4'd0, 3);
        txn("t3_hit0", 11'h090, 1'b1, 4'd2, 1'b0, 0, 4'd0, 3);
        chk("t3_counts", {hit_count, miss_count}, {16'd3, 16'd2});

        // 4: timeout, then still a miss
        txn("t4_tmo", 11'h0A1, 1'b0, 4'd0, 1'b1, 0, 4'd0, 18);
        chk("t4_valid_drop", {30'd0, valid, miss}, 32'd0);
        txn("t4_tmo2", 11'h0A1, 1'b0, 4'd0, 1'b1, 0, 4'd0, 18);
        chk("t4_miss_count", miss_count, 4);

        // 5: bad victim way, then a real fill proves nothing was written
        txn("t5_bad", 11'h0A1, 1'b0, 4'd0, 1'b1, 2, 4'd4, 4);
        chk("t5_miss_count", miss_count, 5);
        txn("t5_refill", 11'h0A1, 1'b0, 4'd1, 1'b0, 1, 4'd1, 3);
        wait_ready();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 11'h090;
        #1 chk("t5_flush_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("t5_not_accepted", {30'd0, valid, req_ready}, 32'd1);
        txn("t5_after_flush", 11'h090, 1'b0, 4'd3, 1'b0, 1, 4'd3, 3);
        chk("t5_counts", {hit_count, miss_count}, {16'd3, 16'd7});

        // 6: reset in the middle of MISS_WAIT
        wait_ready();
        req_valid = 1'b1;
        req_addr  = 11'h095;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_miss", {30'd0, valid, miss}, 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_outs", {29'd0, valid, miss, req_ready}, 32'd0);
        chk("t6_rst_counts", {hit_count, miss_count}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        txn("t6_after", 11'h090, 1'b0, 4'd1, 1'b0, 1, 4'd1, 3);
        chk("t6_miss_count", miss_count, 1);

        // 7: hit counter saturation
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        chk("t7_forced", hit_count, 16'hFFFF);
        txn("t7_hit", 11'h090, 1'b1, 4'd1, 1'b0, 0, 4'd0, 3);
        @(negedge clk);
        chk("t7_saturated", hit_count, 16'hFFFF);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
